// File: rtl/md5_pkg.sv
// Shared constants and state encoding for the MD5 block feeder.
package md5_pkg;

    localparam int MD5_BLOCK_BITS    = 512;
    localparam int MD5_LEN_BITS      = 64;
    localparam int MD5_BLOCK_BYTES   = 64;
    // First byte of the little-endian bit-length field inside a block.
    localparam int MD5_LEN_OFFSET    = 56;
    // Highest byte index the 0x80 marker may occupy while still leaving room
    // for the length field in the same block.
    localparam int MD5_LAST_DATA_IDX = 55;
    localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_EMIT       = 2'd1,
        ST_PAD        = 2'd2,
        ST_EMIT_FINAL = 2'd3
    } state_t;

endpackage

// File: rtl/md5_block_feeder.sv
// Packs a byte stream into 512-bit MD5 blocks, appends the 0x80 marker, zero
// fill and the 64-bit little-endian bit length, and hands blocks downstream.
//
// Handshakes: a byte moves when byte_valid && byte_ready at a rising edge; a
// block moves when block_valid && block_ready at a rising edge. Once raised,
// block_valid stays high with block_out/block_last/msg_bit_length frozen
// until the block is taken, and no bytes are accepted meanwhile.
module md5_block_feeder
    import md5_pkg::*;
#(
    parameter int BLOCK_BITS = MD5_BLOCK_BITS,
    parameter int LEN_BITS   = MD5_LEN_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    input  logic                  flush_empty,
    output logic [BLOCK_BITS-1:0] block_out,
    output logic                  block_valid,
    output logic                  block_last,
    input  logic                  block_ready,
    output logic [LEN_BITS-1:0]   msg_bit_length,
    output state_t                dbg_state
);

    localparam int         CNT_BITS       = LEN_BITS - 3;
    localparam int         LEN_LSB        = MD5_LEN_OFFSET * 8;
    localparam logic [5:0] IDX_LAST       = 6'(MD5_BLOCK_BYTES - 1);
    localparam logic [5:0] IDX_SINGLE_MAX = 6'(MD5_LAST_DATA_IDX - 1);

    state_t                r_state;
    logic [BLOCK_BITS-1:0] r_buf;
    logic [5:0]            r_idx;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_pad_pending;
    logic                  r_pad_mark;
    logic                  r_run;

    state_t                w_state_nxt;
    logic [BLOCK_BITS-1:0] w_buf_nxt;
    logic [5:0]            w_idx_nxt;
    logic [CNT_BITS-1:0]   w_count_nxt;
    logic                  w_pad_nxt;
    logic                  w_mark_nxt;
    logic                  w_byte_fire;
    logic                  w_blk_fire;
    logic [5:0]            w_idx_p1;
    logic [CNT_BITS-1:0]   w_count_inc;

    // r_run keeps byte_ready low until the first edge after reset release.
    assign byte_ready     = r_run && (r_state == ST_FILL);
    assign block_valid    = (r_state == ST_EMIT) || (r_state == ST_EMIT_FINAL);
    assign block_last     = (r_state == ST_EMIT_FINAL);
    assign block_out      = r_buf;
    assign msg_bit_length = {r_count, 3'b000};
    assign dbg_state      = r_state;

    assign w_byte_fire = byte_valid && byte_ready;
    assign w_blk_fire  = block_valid && block_ready;
    assign w_idx_p1    = r_idx + 6'd1;
    assign w_count_inc = r_count + CNT_BITS'(1);

    // State, buffer and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_FILL;
            r_buf         <= '0;
            r_idx         <= '0;
            r_count       <= '0;
            r_pad_pending <= 1'b0;
            r_pad_mark    <= 1'b0;
            r_run         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_buf         <= w_buf_nxt;
            r_idx         <= w_idx_nxt;
            r_count       <= w_count_nxt;
            r_pad_pending <= w_pad_nxt;
            r_pad_mark    <= w_mark_nxt;
            r_run         <= 1'b1;
        end
    end

    // Next-state logic: byte packing, padding and length insertion.
    // The buffer is always cleared after a block leaves, so bytes beyond the
    // write index are already zero and zero fill needs no explicit writes.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_pad_nxt   = r_pad_pending;
        w_mark_nxt  = r_pad_mark;
        case (r_state)
            ST_FILL: begin
                if (w_byte_fire) begin
                    w_buf_nxt[{r_idx, 3'b000} +: 8] = byte_in;
                    w_idx_nxt   = w_idx_p1;
                    w_count_nxt = w_count_inc;
                    if (byte_last) begin
                        if (r_idx <= IDX_SINGLE_MAX) begin
                            // Marker and length both fit in this block.
                            w_buf_nxt[{w_idx_p1, 3'b000} +: 8] = MD5_PAD_BYTE;
                            w_buf_nxt[LEN_LSB +: LEN_BITS]     = {w_count_inc, 3'b000};
                            w_state_nxt = ST_EMIT_FINAL;
                        end else if (r_idx != IDX_LAST) begin
                            // Marker fits, length spills into a pad block.
                            w_buf_nxt[{w_idx_p1, 3'b000} +: 8] = MD5_PAD_BYTE;
                            w_pad_nxt   = 1'b1;
                            w_mark_nxt  = 1'b0;
                            w_state_nxt = ST_EMIT;
                        end else begin
                            // Block is full: marker and length both go to the pad block.
                            w_pad_nxt   = 1'b1;
                            w_mark_nxt  = 1'b1;
                            w_state_nxt = ST_EMIT;
                        end
                    end else if (r_idx == IDX_LAST) begin
                        w_pad_nxt   = 1'b0;
                        w_state_nxt = ST_EMIT;
                    end
                end else if (flush_empty && !byte_valid && (r_count == '0)) begin
                    // Zero-length message: marker at byte 0, length field stays 0.
                    w_buf_nxt[7:0] = MD5_PAD_BYTE;
                    w_state_nxt    = ST_EMIT_FINAL;
                end
            end
            ST_EMIT: begin
                if (w_blk_fire) begin
                    w_buf_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_pad_pending ? ST_PAD : ST_FILL;
                end
            end
            ST_PAD: begin
                w_buf_nxt = '0;
                if (r_pad_mark) begin
                    w_buf_nxt[7:0] = MD5_PAD_BYTE;
                end
                w_buf_nxt[LEN_LSB +: LEN_BITS] = {r_count, 3'b000};
                w_pad_nxt   = 1'b0;
                w_mark_nxt  = 1'b0;
                w_state_nxt = ST_EMIT_FINAL;
            end
            ST_EMIT_FINAL: begin
                if (w_blk_fire) begin
                    w_buf_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

endmodule
